// File: rtl/motion_compare.sv
// motion_compare: frame-differencing stage.
// After each captured frame, scans the frame buffer word by word, compares
// each 4-bit pixel against the reference (previous) frame, writes a per-word
// change mask, copies the current word into the reference buffer and reports
// the number of changed pixels plus a motion flag.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   frame_done                 pulse: new frame ready in the frame buffer
//   pix_thresh, count_thresh   per-pixel / per-frame thresholds (sampled at start)
//   fb_addr, fb_din            frame buffer read port (1-cycle latency)
//   ref_addr, ref_din,
//   ref_we, ref_dout           single-port reference buffer
//   mask_addr, mask_we,
//   mask_dout                  change-mask write port
//   busy, done                 scan in progress / results-valid pulse
//   change_count, motion       last frame result, held until next done
//   overrun                    sticky: frame_done seen while not idle
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for frame_done
// SCAN   | even phase reads word idx, odd phase writes an earlier result
// FLUSH  | two cycles draining the compare pipeline
// REPORT | done pulse cycle, results visible
module motion_compare #(
   parameter int WORDS   = 19200,
   parameter int ADDR_W  = 15,
   parameter int COUNT_W = 17
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               frame_done,
   input  logic [3:0]         pix_thresh,
   input  logic [COUNT_W-1:0] count_thresh,
   output logic [ADDR_W-1:0]  fb_addr,
   input  logic [15:0]        fb_din,
   output logic [ADDR_W-1:0]  ref_addr,
   input  logic [15:0]        ref_din,
   output logic               ref_we,
   output logic [15:0]        ref_dout,
   output logic [ADDR_W-1:0]  mask_addr,
   output logic               mask_we,
   output logic [3:0]         mask_dout,
   output logic               busy,
   output logic               done,
   output logic [COUNT_W-1:0] change_count,
   output logic               motion,
   output logic               overrun
);

   typedef enum logic [1:0] {IDLE, SCAN, FLUSH, REPORT} state_t;

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(WORDS - 1);

   state_t               state_q, state_d;
   logic                 phase_q, phase_d;
   logic [ADDR_W-1:0]    idx_q, idx_d;
   logic                 flush_q, flush_d;
   logic [3:0]           pt_q, pt_d;
   logic [COUNT_W-1:0]   ct_q, ct_d;
   logic [COUNT_W-1:0]   acc_q, acc_d;
   logic                 ref_valid_q, ref_valid_d;
   logic                 overrun_q, overrun_d;
   logic                 done_q, done_d;
   logic [COUNT_W-1:0]   change_count_q, change_count_d;
   logic                 motion_q, motion_d;

   logic                 s1_vld_q, s1_vld_d;
   logic [15:0]          s1_fb_q, s1_fb_d;
   logic [15:0]          s1_ref_q, s1_ref_d;
   logic [ADDR_W-1:0]    s1_idx_q, s1_idx_d;

   logic                 we_q, we_d;
   logic [ADDR_W-1:0]    mask_addr_q, mask_addr_d;
   logic [3:0]           mask_dout_q, mask_dout_d;
   logic [15:0]          ref_dout_q, ref_dout_d;

   logic [3:0]           changed;
   logic [2:0]           pop;

   // Per-nibble absolute difference in 5-bit arithmetic, strict compare.
   always_comb begin
      logic [4:0] a, b, d;
      changed = 4'b0;
      for (int i = 0; i < 4; i++) begin
         a = {1'b0, s1_fb_q[4*i +: 4]};
         b = {1'b0, s1_ref_q[4*i +: 4]};
         d = (a >= b) ? (a - b) : (b - a);
         changed[i] = (d > {1'b0, pt_q});
      end
      pop = {2'b0, changed[0]} + {2'b0, changed[1]}
          + {2'b0, changed[2]} + {2'b0, changed[3]};
   end

   always_comb begin
      state_d        = state_q;
      phase_d        = phase_q;
      idx_d          = idx_q;
      flush_d        = flush_q;
      pt_d           = pt_q;
      ct_d           = ct_q;
      acc_d          = acc_q;
      ref_valid_d    = ref_valid_q;
      overrun_d      = overrun_q;
      done_d         = 1'b0;
      change_count_d = change_count_q;
      motion_d       = motion_q;

      if (frame_done && (state_q != IDLE))
         overrun_d = 1'b1;

      // A priming frame has no meaningful reference, so nothing is counted.
      if (s1_vld_q && ref_valid_q)
         acc_d = acc_q + COUNT_W'(pop);

      case (state_q)
         IDLE: begin
            if (frame_done) begin
               state_d = SCAN;
               pt_d    = pix_thresh;
               ct_d    = count_thresh;
               acc_d   = '0;
               idx_d   = '0;
               phase_d = 1'b0;
            end
         end
         SCAN: begin
            phase_d = ~phase_q;
            if (phase_q) begin
               if (idx_q == LAST_IDX) begin
                  state_d = FLUSH;
                  idx_d   = '0;
                  flush_d = 1'b0;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         FLUSH: begin
            flush_d = 1'b1;
            if (flush_q) begin
               state_d     = REPORT;
               done_d      = ref_valid_q;
               ref_valid_d = 1'b1;
               if (ref_valid_q) begin
                  change_count_d = acc_q;
                  motion_d       = (acc_q > ct_q);
               end
            end
         end
         REPORT: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // S1 captures read data on the odd (write) phase that follows each read;
   // S2 registers the memory writes, which land on the next odd phase.
   always_comb begin
      s1_vld_d    = (state_q == SCAN) && phase_q;
      s1_fb_d     = s1_vld_d ? fb_din  : s1_fb_q;
      s1_ref_d    = s1_vld_d ? ref_din : s1_ref_q;
      s1_idx_d    = s1_vld_d ? idx_q   : s1_idx_q;
      we_d        = s1_vld_q;
      mask_addr_d = mask_addr_q;
      mask_dout_d = mask_dout_q;
      ref_dout_d  = ref_dout_q;
      if (s1_vld_q) begin
         mask_addr_d = s1_idx_q;
         mask_dout_d = ref_valid_q ? changed : 4'b0;
         ref_dout_d  = s1_fb_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         phase_q        <= 1'b0;
         idx_q          <= '0;
         flush_q        <= 1'b0;
         pt_q           <= '0;
         ct_q           <= '0;
         acc_q          <= '0;
         ref_valid_q    <= 1'b0;
         overrun_q      <= 1'b0;
         done_q         <= 1'b0;
         change_count_q <= '0;
         motion_q       <= 1'b0;
         s1_vld_q       <= 1'b0;
         s1_fb_q        <= '0;
         s1_ref_q       <= '0;
         s1_idx_q       <= '0;
         we_q           <= 1'b0;
         mask_addr_q    <= '0;
         mask_dout_q    <= '0;
         ref_dout_q     <= '0;
      end else begin
         state_q        <= state_d;
         phase_q        <= phase_d;
         idx_q          <= idx_d;
         flush_q        <= flush_d;
         pt_q           <= pt_d;
         ct_q           <= ct_d;
         acc_q          <= acc_d;
         ref_valid_q    <= ref_valid_d;
         overrun_q      <= overrun_d;
         done_q         <= done_d;
         change_count_q <= change_count_d;
         motion_q       <= motion_d;
         s1_vld_q       <= s1_vld_d;
         s1_fb_q        <= s1_fb_d;
         s1_ref_q       <= s1_ref_d;
         s1_idx_q       <= s1_idx_d;
         we_q           <= we_d;
         mask_addr_q    <= mask_addr_d;
         mask_dout_q    <= mask_dout_d;
         ref_dout_q     <= ref_dout_d;
      end
   end

   assign fb_addr      = idx_q;
   // Single-port reference: the write slot borrows the address bus.
   assign ref_addr     = we_q ? mask_addr_q : idx_q;
   assign ref_we       = we_q;
   assign ref_dout     = ref_dout_q;
   assign mask_we      = we_q;
   assign mask_addr    = mask_addr_q;
   assign mask_dout    = mask_dout_q;
   assign busy         = (state_q == SCAN) || (state_q == FLUSH);
   assign done         = done_q;
   assign change_count = change_count_q;
   assign motion       = motion_q;
   assign overrun      = overrun_q;

endmodule
